// File: rtl/gpu_pkg.sv
// Shared wireframe-path constants, raster FSM encoding and coordinate types.
// Internal screen positions are 12-bit signed so off-screen points remain representable.
package gpu_pkg;

  localparam int COORD_W  = 10;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;
  localparam int ORIGIN_X = 320;
  localparam int ORIGIN_Y = 240;

  localparam int POS_W = 12;
  localparam int ERR_W = 13;
  localparam int PIX_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_STEP  = 2'd2
  } raster_state_e;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [ERR_W-1:0] err_t;

  // Sign-extend an origin-centred vertex coordinate and shift it into framebuffer space.
  function automatic pos_t to_screen(input logic signed [COORD_W-1:0] v, input int origin);
    return pos_t'(v) + pos_t'(origin);
  endfunction

endpackage

// File: rtl/screen_clip.sv
// Combinational on-screen test of a framebuffer-space point against the visible area.
module screen_clip
  import gpu_pkg::*;
(
  input  pos_t cx,
  input  pos_t cy,
  output logic on_screen
);

  localparam pos_t MAX_X = pos_t'(SCR_W);
  localparam pos_t MAX_Y = pos_t'(SCR_H);

  // A clear sign bit stands in for the >= 0 test.
  assign on_screen = !cx[POS_W-1] && (cx < MAX_X) &&
                     !cy[POS_W-1] && (cy < MAX_Y);

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: accepts an endpoint pair, then emits clipped
// framebuffer pixels one per cycle over a valid/ready handshake.
module line_raster
  import gpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [COORD_W-1:0]  x0,
  input  logic signed [COORD_W-1:0]  y0,
  input  logic signed [COORD_W-1:0]  x1,
  input  logic signed [COORD_W-1:0]  y1,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [PIX_W-1:0]           pix_x,
  output logic [PIX_W-1:0]           pix_y,
  output logic                       busy,
  output logic                       done
);

  localparam pos_t POS_ONE = pos_t'(1);

  raster_state_e state, state_n;

  logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  pos_t cx, cy, ex, ey;
  err_t dx, dy, err;
  logic sx_neg, sy_neg;
  logic done_q;

  // Setup arithmetic on the latched endpoints
  pos_t sx0, sy0, sx1, sy1, diff_x, diff_y, abs_x, abs_y;
  err_t setup_dx, setup_dy;

  assign sx0      = to_screen(x0_q, ORIGIN_X);
  assign sy0      = to_screen(y0_q, ORIGIN_Y);
  assign sx1      = to_screen(x1_q, ORIGIN_X);
  assign sy1      = to_screen(y1_q, ORIGIN_Y);
  assign diff_x   = sx1 - sx0;
  assign diff_y   = sy1 - sy0;
  assign abs_x    = diff_x[POS_W-1] ? -diff_x : diff_x;
  assign abs_y    = diff_y[POS_W-1] ? -diff_y : diff_y;
  assign setup_dx = err_t'(abs_x);
  assign setup_dy = -err_t'(abs_y);

  // Step decision for the current point
  logic on_screen, advance, at_end, step_x, step_y;
  err_t e2, err_next;

  screen_clip u_clip (
    .cx        (cx),
    .cy        (cy),
    .on_screen (on_screen)
  );

  assign e2      = err <<< 1;
  assign step_x  = (e2 >= dy);
  assign step_y  = (e2 <= dx);
  assign at_end  = (cx == ex) && (cy == ey);
  // Off-screen points never wait on the consumer.
  assign advance = (state == ST_STEP) && (!on_screen || pix_ready);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    err_next = err;
    if (step_x) err_next = err_next + dy;
    if (step_y) err_next = err_next + dx;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (in_valid) state_n = ST_SETUP;
      ST_SETUP: state_n = ST_STEP;
      ST_STEP:  if (advance && at_end) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    busy      = (state == ST_SETUP) || (state == ST_STEP);
    pix_valid = (state == ST_STEP) && on_screen;
    pix_x     = '0;
    pix_y     = '0;
    if (pix_valid) begin
      pix_x = cx[PIX_W-1:0];
      pix_y = cy[PIX_W-1:0];
    end
    done      = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q   <= '0;
      y0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      cx     <= '0;
      cy     <= '0;
      ex     <= '0;
      ey     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= advance && at_end;
      if (state == ST_IDLE && in_valid) begin
        x0_q <= x0;
        y0_q <= y0;
        x1_q <= x1;
        y1_q <= y1;
      end
      if (state == ST_SETUP) begin
        cx     <= sx0;
        cy     <= sy0;
        ex     <= sx1;
        ey     <= sy1;
        dx     <= setup_dx;
        dy     <= setup_dy;
        err    <= setup_dx + setup_dy;
        sx_neg <= diff_x[POS_W-1];
        sy_neg <= diff_y[POS_W-1];
      end else if (advance && !at_end) begin
        err <= err_next;
        if (step_x) cx <= sx_neg ? cx - POS_ONE : cx + POS_ONE;
        if (step_y) cy <= sy_neg ? cy - POS_ONE : cy + POS_ONE;
      end
    end
  end

endmodule

// File: tb/tb_line_raster.sv
// Scoreboard bench for line_raster: stimulus pushes expected pixels, a monitor
// pops and compares on each pixel handshake and checks done timing and stall hold.
module tb_line_raster;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic pix_valid;
  logic pix_ready = 1'b1;
  logic [PIX_W-1:0] pix_x, pix_y;
  logic busy, done;

  line_raster dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y;} pix_t;
  pix_t sb[$];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_count = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  bit prev_stall = 1'b0;
  int prev_xy = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pix_t e;
    int xy;
    cyc++;
    xy = int'(pix_x) * 1000 + int'(pix_y);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", int'(pix_valid), 1);
        check_eq("hold_xy", xy, prev_xy);
      end
      if (pix_valid) begin
        check_eq("valid_only_when_busy", int'(busy), 1);
        if (pix_ready) begin
          hs_count++;
          last_hs_cyc = cyc;
          if (sb.size() == 0) begin
            check_eq("unexpected_pixel", xy, -1);
          end else begin
            e = sb.pop_front();
            check_eq("pixel_xy", xy, e.x * 1000 + e.y);
          end
        end
      end
      if (done) begin
        done_count++;
        check_eq("done_all_pixels_seen", sb.size(), 0);
        check_eq("done_after_last_pixel", cyc, last_hs_cyc + 1);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_xy    = xy;
    end
  end

  task automatic push_row(input int xa, input int xb, input int y);
    for (int x = xa; x <= xb; x++) sb.push_back('{x: x, y: y});
  endtask

  task automatic push_pix(input int x, input int y);
    sb.push_back('{x: x, y: y});
  endtask

  // Returns one cycle after the accepting edge, i.e. during SETUP.
  task automatic send(input int a, input int b, input int c, input int d);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("in_ready_before_send", int'(in_ready), 1);
    x0 = COORD_W'(a);
    y0 = COORD_W'(b);
    x1 = COORD_W'(c);
    y1 = COORD_W'(d);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_n);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 500) begin
      @(negedge clk);
      n++;
      got = done;
    end
    check_eq({name, "_done_seen"}, int'(got), 1);
    check_eq({name, "_done_cycle"}, n, exp_n);
    check_eq({name, "_in_ready_at_done"}, int'(in_ready), 1);
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (hs_count < target && t < 100);
    check_eq("handshake_reached", int'(hs_count >= target), 1);
  endtask

  initial begin
    int base;
    int dc;

    // Reset state, sampled while rst_n is still low
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_pix_valid", int'(pix_valid), 0);
    check_eq("rst_pix_xy", int'(pix_x) * 1000 + int'(pix_y), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    rst_n = 1'b1;

    // 1: horizontal line, free-running consumer
    send(-2, 0, 2, 0);
    check_eq("setup_busy", int'(busy), 1);
    check_eq("setup_no_pixel", int'(pix_valid), 0);
    check_eq("setup_not_ready", int'(in_ready), 0);
    push_row(318, 322, 240);
    wait_done("t1", 7);

    // 2: steep line, exact Bresenham sequence
    send(0, 0, 2, 4);
    push_pix(320, 240); push_pix(321, 241); push_pix(321, 242);
    push_pix(322, 243); push_pix(322, 244);
    wait_done("t2", 7);

    // 3: test 1 with a 3-cycle stall on the second pixel
    base = hs_count;
    send(-2, 0, 2, 0);
    push_row(318, 322, 240);
    fork
      wait_done("t3", 10);
      begin
        wait_hs(base + 1);
        #1 pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 pix_ready = 1'b1;
      end
    join
    check_eq("t3_pixel_count", hs_count - base, 5);

    // 4: line starting off the left edge
    base = hs_count;
    send(-330, 0, -315, 0);
    push_row(0, 5, 240);
    wait_done("t4", 18);
    check_eq("t4_pixel_count", hs_count - base, 6);

    // 5: degenerate single point
    send(0, 0, 0, 0);
    push_pix(320, 240);
    wait_done("t5", 3);

    // 6: reset mid-line aborts without done
    base = hs_count;
    send(0, 0, 2, 4);
    push_pix(320, 240); push_pix(321, 241); push_pix(321, 242);
    push_pix(322, 243); push_pix(322, 244);
    wait_hs(base + 2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_pix_valid", int'(pix_valid), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_in_ready", int'(in_ready), 1);
    sb.delete();
    dc = done_count;
    repeat (4) @(negedge clk);
    check_eq("abort_no_done", done_count, dc);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Test 1 again after reset, with in_valid pulsed while busy
    send(-2, 0, 2, 0);
    push_row(318, 322, 240);
    x0 = COORD_W'(100);
    y0 = COORD_W'(50);
    x1 = COORD_W'(-100);
    y1 = COORD_W'(-50);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("t6", 6);
    repeat (4) @(negedge clk);
    check_eq("t6_busy_ignored_in_valid", int'(busy), 0);
    check_eq("t6_no_extra_pixels", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
